// File: rtl/i2c_wb_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2c_wb_cmd_sequencer_if
//
// Wishbone link between the command sequencer (master) and the I2C master
// controller's register port (slave): 3-bit address, 8-bit data, classic
// single-access handshake with cyc/stb/ack.
//
// Signals
//   wbm_adr_o  master -> slave  register address (3 = TXR/RXR, 4 = CR/SR)
//   wbm_dat_o  master -> slave  write data
//   wbm_dat_i  slave  -> master read data, valid in the ack cycle
//   wbm_we_o   master -> slave  1 = write, 0 = read
//   wbm_stb_o  master -> slave  strobe
//   wbm_cyc_o  master -> slave  cycle (always equal to strobe here)
//   wbm_ack_i  slave  -> master acknowledge
//
// Modports: master (sequencer side), slave (controller side).
// ---------------------------------------------------------------------------
interface i2c_wb_cmd_sequencer_if;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_we_o;
  logic       wbm_stb_o;
  logic       wbm_cyc_o;
  logic       wbm_ack_i;

  modport master (
    output wbm_adr_o,
    output wbm_dat_o,
    output wbm_we_o,
    output wbm_stb_o,
    output wbm_cyc_o,
    input  wbm_dat_i,
    input  wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o,
    input  wbm_dat_o,
    input  wbm_we_o,
    input  wbm_stb_o,
    input  wbm_cyc_o,
    output wbm_dat_i,
    output wbm_ack_i
  );
endinterface

// File: rtl/i2c_wb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_wb_cmd_sequencer
//
// Turns one register-level command (read or write one byte at an 8-bit
// register of a 7-bit I2C device) into the complete TXR/CR write and SR/RXR
// read sequence for an I2C master controller attached over Wishbone.
//
// Parameters
//   POLL_GAP        idle cycles between a CR-write ack and the first SR poll
//                   (minimum 2 so the controller has raised TIP)
//   TIMEOUT_CYCLES  polling budget per byte transfer (timeout build only)
//
// Ports
//   wb_clk_i     clock
//   arst_i       asynchronous active-high reset
//   cmd_valid_i  command request; accepted when cmd_ready_o is high
//   cmd_ready_o  high only while idle
//   cmd_rw_i     1 = read, 0 = write
//   cmd_dev_i    7-bit I2C device address
//   cmd_reg_i    device register address
//   cmd_wdata_i  write data
//   rsp_valid_o  one-cycle completion pulse
//   rsp_rdata_o  read data, held until the next rsp_valid_o
//   rsp_err_o    00 ok, 01 NACK, 10 arbitration lost, 11 timeout
//   busy_o       high whenever not idle
//   wbm          Wishbone master port (i2c_wb_cmd_sequencer_if.master)
//
// Optional feature macro: I2C_SEQ_TIMEOUT_EN
//   Defined: polling is bounded by TIMEOUT_CYCLES; on expiry a STOP is
//   issued and the command completes with err 11.
//   Undefined: polling is unbounded and err 11 never occurs.
// ---------------------------------------------------------------------------
module i2c_wb_cmd_sequencer #(
  parameter int POLL_GAP       = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                          wb_clk_i,
  input  logic                          arst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_rw_i,
  input  logic [6:0]                    cmd_dev_i,
  input  logic [7:0]                    cmd_reg_i,
  input  logic [7:0]                    cmd_wdata_i,
  output logic                          rsp_valid_o,
  output logic [7:0]                    rsp_rdata_o,
  output logic [1:0]                    rsp_err_o,
  output logic                          busy_o,
  i2c_wb_cmd_sequencer_if.master        wbm
);

  localparam logic [2:0] ADR_TXR = 3'd3;  // TXR write / RXR read
  localparam logic [2:0] ADR_CR  = 3'd4;  // CR write / SR read

  localparam logic [7:0] CR_STO = 8'h40;

  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_AL   = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  // GAP lasts POLL_GAP-1 cycles; the strobe-raise cycle of POLL supplies the
  // last idle cycle, so exactly POLL_GAP idle cycles separate ack and poll.
  localparam int GAP_LAST = (POLL_GAP > 2) ? POLL_GAP - 2 : 0;
  localparam int GAP_W    = $clog2(GAP_LAST + 2);

  typedef enum logic [3:0] {
    IDLE, WR_TXR, WR_CR, GAP, POLL, RD_RXR, STOP_CR, STOP_POLL, DONE
  } state_t;

  state_t             state_reg;
  logic [1:0]         step_reg;
  logic               rw_reg;
  logic [6:0]         dev_reg;
  logic [7:0]         regaddr_reg;
  logic [7:0]         wdata_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic               tmo_flag_reg;

  logic               cmd_ready_reg;
  logic               busy_reg;
  logic               rsp_valid_reg;
  logic [7:0]         rsp_rdata_reg;
  logic [1:0]         rsp_err_reg;
  logic               stb_reg;
  logic [2:0]         adr_reg;
  logic [7:0]         dat_reg;
  logic               we_reg;

  logic [7:0]         txr_val;
  logic [7:0]         cr_val;
  logic               read_step;
  logic               tmo_hit;

  // Step 0: device address (write), step 1: register address,
  // step 2: data byte (write) or device address with R bit (repeated start),
  // step 3: read data byte with STOP and NACK.
  always_comb begin
    txr_val = 8'h00;
    cr_val  = 8'h90;
    case (step_reg)
      2'd0: begin
        txr_val = {dev_reg, 1'b0};
        cr_val  = 8'h90;
      end
      2'd1: begin
        txr_val = regaddr_reg;
        cr_val  = 8'h10;
      end
      2'd2: begin
        txr_val = rw_reg ? {dev_reg, 1'b1} : wdata_reg;
        cr_val  = rw_reg ? 8'h90 : 8'h50;
      end
      default: begin
        txr_val = 8'h00;
        cr_val  = 8'h68;
      end
    endcase
  end

  // Only the final byte of a read is received; every other byte is sent and
  // therefore has an RxACK to check.
  assign read_step = rw_reg & (step_reg == 2'd3);

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;

  // Cleared as GAP is entered after each byte's CR write; saturates on hit.
  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == WR_CR && stb_reg && wbm.wbm_ack_i) begin
      tmo_cnt_reg <= '0;
    end else if ((state_reg == GAP || state_reg == POLL || state_reg == STOP_POLL)
                 && !tmo_hit) begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end
  end

  assign tmo_hit = (tmo_cnt_reg >= 16'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      rw_reg        <= 1'b0;
      dev_reg       <= '0;
      regaddr_reg   <= '0;
      wdata_reg     <= '0;
      gap_cnt_reg   <= '0;
      tmo_flag_reg  <= 1'b0;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= '0;
      stb_reg       <= 1'b0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      we_reg        <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_reg) begin
            rw_reg        <= cmd_rw_i;
            dev_reg       <= cmd_dev_i;
            regaddr_reg   <= cmd_reg_i;
            wdata_reg     <= cmd_wdata_i;
            step_reg      <= 2'd0;
            tmo_flag_reg  <= 1'b0;
            cmd_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= WR_TXR;
          end
        end

        // Bus states raise the strobe on their first cycle with address and
        // data already valid, and drop it on the edge the ack is seen.
        WR_TXR: begin
          if (!stb_reg) begin
            stb_reg <= 1'b1;
            adr_reg <= ADR_TXR;
            dat_reg <= txr_val;
            we_reg  <= 1'b1;
          end else if (wbm.wbm_ack_i) begin
            stb_reg   <= 1'b0;
            we_reg    <= 1'b0;
            state_reg <= WR_CR;
          end
        end

        WR_CR: begin
          if (!stb_reg) begin
            stb_reg <= 1'b1;
            adr_reg <= ADR_CR;
            dat_reg <= cr_val;
            we_reg  <= 1'b1;
          end else if (wbm.wbm_ack_i) begin
            stb_reg     <= 1'b0;
            we_reg      <= 1'b0;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end
        end

        GAP: begin
          if (tmo_hit) begin
            tmo_flag_reg <= 1'b1;
            state_reg    <= STOP_CR;
          end else if (gap_cnt_reg >= GAP_W'(GAP_LAST)) begin
            state_reg <= POLL;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        POLL, STOP_POLL: begin
          if (!stb_reg) begin
            if (tmo_hit) begin
              tmo_flag_reg <= 1'b1;
              state_reg    <= STOP_CR;
            end else begin
              stb_reg <= 1'b1;
              adr_reg <= ADR_CR;
              we_reg  <= 1'b0;
            end
          end else if (wbm.wbm_ack_i) begin
            stb_reg <= 1'b0;
            if (wbm.wbm_dat_i[SR_AL]) begin
              // The controller has already released the bus: no STOP.
              rsp_err_reg   <= ERR_AL;
              rsp_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (tmo_hit) begin
              tmo_flag_reg <= 1'b1;
              state_reg    <= STOP_CR;
            end else if (!wbm.wbm_dat_i[SR_TIP]) begin
              if (state_reg == STOP_POLL) begin
                rsp_err_reg   <= ERR_NACK;
                rsp_valid_reg <= 1'b1;
                state_reg     <= DONE;
              end else if (!read_step && wbm.wbm_dat_i[SR_RXACK]) begin
                state_reg <= STOP_CR;
              end else if (step_reg == 2'd3) begin
                state_reg <= RD_RXR;
              end else if (step_reg == 2'd2 && !rw_reg) begin
                rsp_err_reg   <= ERR_OK;
                rsp_valid_reg <= 1'b1;
                state_reg     <= DONE;
              end else begin
                step_reg  <= step_reg + 2'd1;
                // The read-data byte has no TXR load.
                state_reg <= (step_reg == 2'd2) ? WR_CR : WR_TXR;
              end
            end
          end
        end

        RD_RXR: begin
          if (!stb_reg) begin
            stb_reg <= 1'b1;
            adr_reg <= ADR_TXR;
            we_reg  <= 1'b0;
          end else if (wbm.wbm_ack_i) begin
            stb_reg       <= 1'b0;
            rsp_rdata_reg <= wbm.wbm_dat_i;
            rsp_err_reg   <= ERR_OK;
            rsp_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end

        STOP_CR: begin
          if (!stb_reg) begin
            stb_reg <= 1'b1;
            adr_reg <= ADR_CR;
            dat_reg <= CR_STO;
            we_reg  <= 1'b1;
          end else if (wbm.wbm_ack_i) begin
            stb_reg <= 1'b0;
            we_reg  <= 1'b0;
            if (tmo_flag_reg) begin
              // A stuck transfer is not polled again after the STOP.
              rsp_err_reg   <= ERR_TMO;
              rsp_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              state_reg <= STOP_POLL;
            end
          end
        end

        DONE: begin
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_reg;
  assign busy_o        = busy_reg;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_rdata_o   = rsp_rdata_reg;
  assign rsp_err_o     = rsp_err_reg;
  assign wbm.wbm_stb_o = stb_reg;
  assign wbm.wbm_cyc_o = stb_reg;
  assign wbm.wbm_adr_o = adr_reg;
  assign wbm.wbm_dat_o = dat_reg;
  assign wbm.wbm_we_o  = we_reg;

endmodule

// File: tb/tb_i2c_wb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_wb_cmd_sequencer
//
// Drives register-level commands into i2c_wb_cmd_sequencer against a small
// behavioural model of the I2C controller's Wishbone register port. Each
// table record holds a command, the controller behaviour (TIP polls, NACK
// byte, AL byte, RXR value) and the hand-derived bus write sequence and
// response. Reset-mid-poll and (when I2C_SEQ_TIMEOUT_EN is defined) the
// timeout path are written out as separate sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_wb_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;

  always #5 clk = ~clk;

  i2c_wb_cmd_sequencer_if bus();

  i2c_wb_cmd_sequencer #(
    .POLL_GAP       (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .wb_clk_i    (clk),
    .arst_i      (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_rw_i    (cmd_rw),
    .cmd_dev_i   (cmd_dev),
    .cmd_reg_i   (cmd_reg),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .busy_o      (busy),
    .wbm         (bus)
  );

  // ---------------- controller register-port model ----------------
  int          nack_byte = 0;   // CR-write index (1-based) whose SR shows RxACK=1
  int          al_byte   = 0;   // CR-write index whose SR shows AL=1
  int          tip_polls = 0;   // SR reads returning TIP=1 after each CR write
  bit          tip_stuck = 1'b0;
  logic [7:0]  rxr_val   = 8'h00;
  int          cr_base   = 0;

  int          wr_cnt  = 0;
  int          cr_cnt  = 0;
  int          tip_left = 0;
  int          rsp_cnt = 0;
  logic [10:0] wr_log [0:1023];

  always @(posedge clk) begin
    if (rst) begin
      bus.wbm_ack_i <= 1'b0;
      bus.wbm_dat_i <= 8'h00;
    end else begin
      bus.wbm_ack_i <= 1'b0;
      if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i) begin
        bus.wbm_ack_i <= 1'b1;
        if (bus.wbm_we_o) begin
          wr_log[wr_cnt % 1024] <= {bus.wbm_adr_o, bus.wbm_dat_o};
          wr_cnt <= wr_cnt + 1;
          bus.wbm_dat_i <= 8'h00;
          if (bus.wbm_adr_o == 3'd4) begin
            cr_cnt   <= cr_cnt + 1;
            tip_left <= tip_polls;
          end
        end else if (bus.wbm_adr_o == 3'd4) begin
          if (tip_stuck || tip_left != 0) begin
            bus.wbm_dat_i <= 8'h02;
            if (tip_left != 0) tip_left <= tip_left - 1;
          end else begin
            bus.wbm_dat_i <= (((cr_cnt - cr_base) == nack_byte) ? 8'h80 : 8'h00) |
                             (((cr_cnt - cr_base) == al_byte)   ? 8'h20 : 8'h00);
          end
        end else begin
          bus.wbm_dat_i <= rxr_val;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic             rw;
    logic [6:0]       dev;
    logic [7:0]       ra;
    logic [7:0]       wd;
    logic [7:0]       rxr;
    int               nack;
    int               al;
    int               polls;
    logic [1:0]       err;
    logic [7:0]       rdata;
    int               nwr;
    logic [0:7][10:0] wr;     // expected {adr, dat} writes in bus order
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input string tag);
    int wr0;
    int rsp0;
    int n;
    bit seen;
    nack_byte = v.nack;
    al_byte   = v.al;
    tip_polls = v.polls;
    rxr_val   = v.rxr;
    cr_base   = cr_cnt;
    wr0       = wr_cnt;
    rsp0      = rsp_cnt;
    @(negedge clk);
    check({tag, ".ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_rw    = v.rw;
    cmd_dev   = v.dev;
    cmd_reg   = v.ra;
    cmd_wdata = v.wd;
    @(negedge clk);
    check({tag, ".busy"}, busy, 1);
    // Different command offered while busy: must be ignored.
    cmd_rw    = ~v.rw;
    cmd_dev   = 7'h0F;
    cmd_reg   = 8'hEE;
    cmd_wdata = 8'h11;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      if (rsp_valid) seen = 1'b1;
    end
    check({tag, ".rsp_seen"}, seen, 1);
    if (seen) begin
      check({tag, ".err"}, rsp_err, v.err);
      check({tag, ".rdata"}, rsp_rdata, v.rdata);
      check({tag, ".ready_at_rsp"}, cmd_ready, 0);
      @(negedge clk);
      check({tag, ".rsp_one_cycle"}, rsp_valid, 0);
      check({tag, ".ready_after"}, cmd_ready, 1);
      check({tag, ".busy_after"}, busy, 0);
    end
    check({tag, ".n_writes"}, wr_cnt - wr0, v.nwr);
    for (int i = 0; i < v.nwr; i++)
      check($sformatf("%s.wr%0d", tag, i), wr_log[(wr0 + i) % 1024], v.wr[i]);
    check({tag, ".rsp_count"}, rsp_cnt - rsp0, 1);
    $display("txn %s: rw=%0d dev=%02h reg=%02h err=%0d rdata=%02h writes=%0d",
             tag, v.rw, v.dev, v.ra, rsp_err, rsp_rdata, wr_cnt - wr0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int rsp0;
    int n;
    bit seen;

    //           rw    dev    reg    wdata  rxr    nack al polls err    rdata  nwr writes
    vecs[0] = '{1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 0, 2, 2'b00, 8'h00, 6,
                {11'h3A0, 11'h490, 11'h312, 11'h410, 11'h3A5, 11'h450, 11'h000, 11'h000}};
    vecs[1] = '{1'b1, 7'h50, 8'h03, 8'h00, 8'h3C, 0, 0, 1, 2'b00, 8'h3C, 7,
                {11'h3A0, 11'h490, 11'h303, 11'h410, 11'h3A1, 11'h490, 11'h468, 11'h000}};
    vecs[2] = '{1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 1, 0, 2, 2'b01, 8'h3C, 3,
                {11'h3A0, 11'h490, 11'h440, 11'h000, 11'h000, 11'h000, 11'h000, 11'h000}};
    vecs[3] = '{1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, 0, 2, 3, 2'b10, 8'h3C, 4,
                {11'h3A0, 11'h490, 11'h312, 11'h410, 11'h000, 11'h000, 11'h000, 11'h000}};
    vecs[4] = '{1'b0, 7'h2A, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 2'b00, 8'h3C, 6,
                {11'h354, 11'h490, 11'h3FF, 11'h410, 11'h300, 11'h450, 11'h000, 11'h000}};
    vecs[5] = '{1'b1, 7'h7F, 8'h80, 8'h00, 8'hC3, 0, 0, 2, 2'b00, 8'hC3, 7,
                {11'h3FE, 11'h490, 11'h380, 11'h410, 11'h3FF, 11'h490, 11'h468, 11'h000}};
    vecs[6] = '{1'b0, 7'h10, 8'h01, 8'h77, 8'h00, 3, 0, 1, 2'b01, 8'hC3, 7,
                {11'h320, 11'h490, 11'h301, 11'h410, 11'h377, 11'h450, 11'h440, 11'h000}};
    vecs[7] = '{1'b1, 7'h50, 8'h03, 8'h00, 8'h00, 3, 0, 2, 2'b01, 8'hC3, 7,
                {11'h3A0, 11'h490, 11'h303, 11'h410, 11'h3A1, 11'h490, 11'h440, 11'h000}};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_dev   = '0;
    cmd_reg   = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);

    check("reset.cmd_ready", cmd_ready, 1);
    check("reset.busy", busy, 0);
    check("reset.rsp_valid", rsp_valid, 0);
    check("reset.rsp_err", rsp_err, 0);
    check("reset.rsp_rdata", rsp_rdata, 0);
    check("reset.stb", bus.wbm_stb_o, 0);
    check("reset.cyc", bus.wbm_cyc_o, 0);
    check("reset.we", bus.wbm_we_o, 0);
    check("reset.adr", bus.wbm_adr_o, 0);
    check("reset.dat", bus.wbm_dat_o, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while polling SR: bus released and busy dropped without waiting
    // for a clock, no STOP written, no response.
    tip_stuck = 1'b1;
    nack_byte = 0;
    al_byte   = 0;
    tip_polls = 0;
    cr_base   = cr_cnt;
    wr0       = wr_cnt;
    rsp0      = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_dev   = 7'h50;
    cmd_reg   = 8'h12;
    cmd_wdata = 8'hA5;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.wbm_stb_o && bus.wbm_adr_o == 3'd4 && !bus.wbm_we_o) seen = 1'b1;
    end
    check("rst_poll.reached_poll", seen, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_poll.stb", bus.wbm_stb_o, 0);
    check("rst_poll.cyc", bus.wbm_cyc_o, 0);
    check("rst_poll.busy", busy, 0);
    check("rst_poll.ready", cmd_ready, 1);
    @(negedge clk);
    rst       = 1'b0;
    tip_stuck = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_poll.no_rsp", rsp_cnt - rsp0, 0);
    check("rst_poll.no_sto", wr_cnt - wr0, 2);
    check("rst_poll.rdata_cleared", rsp_rdata, 0);
    $display("txn rst_poll: writes before reset=%0d rsp=%0d", wr_cnt - wr0, rsp_cnt - rsp0);

    run_vec(vecs[0], "after_rst");

`ifdef I2C_SEQ_TIMEOUT_EN
    // TIP never clears: STOP written, err 11 within the polling budget.
    tip_stuck = 1'b1;
    nack_byte = 0;
    al_byte   = 0;
    tip_polls = 0;
    cr_base   = cr_cnt;
    wr0       = wr_cnt;
    rsp0      = rsp_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_dev   = 7'h50;
    cmd_reg   = 8'h12;
    cmd_wdata = 8'hA5;
    @(negedge clk);
    cmd_valid = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (rsp_valid) seen = 1'b1;
    end
    check("tmo.rsp_seen", seen, 1);
    check("tmo.err", rsp_err, 3);
    check("tmo.latency_in_range", int'(n >= 100 && n <= 130), 1);
    check("tmo.n_writes", wr_cnt - wr0, 3);
    check("tmo.wr0", wr_log[wr0 % 1024], 11'h3A0);
    check("tmo.wr1", wr_log[(wr0 + 1) % 1024], 11'h490);
    check("tmo.wr2", wr_log[(wr0 + 2) % 1024], 11'h440);
    tip_stuck = 1'b0;
    @(negedge clk);
    check("tmo.ready_after", cmd_ready, 1);
    $display("txn timeout: err=%0d cycles=%0d writes=%0d", rsp_err, n, wr_cnt - wr0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
